// File: rtl/spi_cfg_ctrl_pkg.sv
// rtl/spi_cfg_ctrl_pkg.sv - register map, reset defaults and FSM states for spi_cfg_ctrl
// Purpose: shared constants for the SPI configuration controller.
//   REG_*      : 2-bit register addresses
//   DEF_*      : reset / default register values
//   spi_state_e: frame decoder states
//   reg_read() : read-back mux of the committed register view
package spi_cfg_ctrl_pkg;

  localparam logic [1:0] REG_BG    = 2'd0;
  localparam logic [1:0] REG_COLOR = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_ID    = 2'd3;

  localparam logic [7:0] DEF_BG    = 8'h00;
  localparam logic [5:0] DEF_COLOR = 6'b101010;
  localparam logic       DEF_AUDIO = 1'b1;
  localparam logic [7:0] DEF_ID    = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

  // Reads always come from the active (committed) registers, never the shadows.
  function automatic logic [7:0] reg_read(input logic [1:0] addr,
                                          input logic [7:0] bg,
                                          input logic [5:0] color,
                                          input logic       audio,
                                          input logic [7:0] id);
    logic [7:0] r;
    case (addr)
      REG_BG:    r = bg;
      REG_COLOR: r = {2'b00, color};
      REG_CTRL:  r = {7'b0000000, audio};
      default:   r = id;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_cfg_ctrl_if.sv
// rtl/spi_cfg_ctrl_if.sv - SPI pin bundle between host and configuration controller
// Purpose: groups the four SPI wires.
//   spi_sclk : SPI clock, mode 0 (host -> slave)
//   spi_cs_n : chip select, active low (host -> slave)
//   spi_mosi : serial data in, MSB first (host -> slave)
//   spi_miso : serial data out, MSB first (slave -> host)
interface spi_cfg_ctrl_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_cfg_ctrl_sync_edge.sv
// rtl/spi_cfg_ctrl_sync_edge.sv - N-stage synchronizer with rise/fall pulses for one bit
// Purpose: brings one asynchronous SPI wire into the clk domain.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input
//   level    : synchronized level (last stage)
//   rise     : 1-cycle pulse on a 0->1 transition seen across the last two stages
//   fall     : 1-cycle pulse on a 1->0 transition seen across the last two stages
module spi_cfg_ctrl_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // RST_VAL lets cs_n reset high so reset release never looks like a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[N-1];
  assign rise  = sync_q[N-2] & ~sync_q[N-1];
  assign fall  = ~sync_q[N-2] & sync_q[N-1];

endmodule

// File: rtl/spi_cfg_ctrl.sv
// rtl/spi_cfg_ctrl.sv - SPI slave register controller with frame-synchronous commit
// Purpose: decodes {cmd, data...} SPI frames, stages writes in shadow registers and
// commits them to the active video/audio configuration on frame_start.
//   clk, rst         : system clock (>= 4x sclk), async active-high reset
//   spi              : SPI slave pins (sclk, cs_n, mosi in; miso out)
//   frame_start      : 1-cycle commit strobe at start of vertical blank
//   background_state : active background mode
//   solid_color      : active RRGGBB colour
//   audio_en         : active audio enable
//   cfg_pending      : shadows written since the last commit
module spi_cfg_ctrl
  import spi_cfg_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = DEF_ID,
  parameter logic [7:0] RST_BG      = DEF_BG,
  parameter logic [5:0] RST_COLOR   = DEF_COLOR,
  parameter logic       RST_AUDIO   = DEF_AUDIO
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cfg_ctrl_if.slave        spi,
  input  logic                 frame_start,
  output logic [7:0]           background_state,
  output logic [5:0]           solid_color,
  output logic                 audio_en,
  output logic                 cfg_pending
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_cfg_ctrl_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.spi_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_cfg_ctrl_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi.spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_cfg_ctrl_sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi.spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Outputs of the shared synchronizer this block has no use for.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic [1:0] addr_q, addr_d;
  logic       rw_q, rw_d;
  logic [7:0] bg_sh_q, bg_sh_d, bg_q, bg_d;
  logic [5:0] color_sh_q, color_sh_d, color_q, color_d;
  logic       audio_sh_q, audio_sh_d, audio_q, audio_d;
  logic       pending_q, pending_d;
  logic [7:0] rx_byte;
  logic       wr_en;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    bg_sh_d    = bg_sh_q;
    color_sh_d = color_sh_q;
    audio_sh_d = audio_sh_q;
    bg_d       = bg_q;
    color_d    = color_q;
    audio_d    = audio_q;
    pending_d  = pending_q;
    wr_en      = 1'b0;
    rx_byte    = {rx_q[6:0], mosi_lvl};

    // Commit copies the shadows as they were before any write landing this cycle.
    if (frame_start && pending_q) begin
      bg_d      = bg_sh_q;
      color_d   = color_sh_q;
      audio_d   = audio_sh_q;
      pending_d = 1'b0;
    end

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      miso_d    = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == ST_CMD) begin
            // Reserved bits [6:2] are ignored.
            rw_d    = rx_byte[7];
            addr_d  = rx_byte[1:0];
            state_d = ST_DATA;
            if (rx_byte[7]) begin
              tx_d = reg_read(rx_byte[1:0], bg_q, color_q, audio_q, ID_VALUE);
            end
          end else begin
            if (!rw_q) begin
              case (addr_q)
                REG_BG:    begin bg_sh_d    = rx_byte;    wr_en = 1'b1; end
                REG_COLOR: begin color_sh_d = rx_byte[5:0]; wr_en = 1'b1; end
                REG_CTRL:  begin audio_sh_d = rx_byte[0]; wr_en = 1'b1; end
                default:   ;
              endcase
            end else begin
              tx_d = reg_read(addr_q + 2'd1, bg_q, color_q, audio_q, ID_VALUE);
            end
            addr_d = addr_q + 2'd1;
          end
        end
      end else if (sclk_fall) begin
        // The first fall after a load presents bit 7, so MISO leads the host's rise sample.
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end

    if (cs_lvl) begin
      miso_d = 1'b0;
    end

    if (wr_en) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      miso_q     <= 1'b0;
      addr_q     <= 2'd0;
      rw_q       <= 1'b0;
      bg_sh_q    <= RST_BG;
      color_sh_q <= RST_COLOR;
      audio_sh_q <= RST_AUDIO;
      bg_q       <= RST_BG;
      color_q    <= RST_COLOR;
      audio_q    <= RST_AUDIO;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      bg_sh_q    <= bg_sh_d;
      color_sh_q <= color_sh_d;
      audio_sh_q <= audio_sh_d;
      bg_q       <= bg_d;
      color_q    <= color_d;
      audio_q    <= audio_d;
      pending_q  <= pending_d;
    end
  end

  assign spi.spi_miso     = miso_q;
  assign background_state = bg_q;
  assign solid_color      = color_q;
  assign audio_en         = audio_q;
  assign cfg_pending      = pending_q;

endmodule
